sram_1r1w_masked: RTL and testbench

Parametrised successor to the single-port masked SRAM models. It provides one read port and one write port, usable in the same cycle, with N-segment write masks and a configurable read-under-write bypass. Reads return deterministic data, and a read result can be held across idle cycles. After reset, a self-clearing init sequencer zeroes every entry before either port accepts traffic. It is used for predictor, tag and metadata arrays that need a known-zero state without software flushing.

---
 rtl/sram_1r1w_masked.sv | 134 +++++++++++++
 tb/tb_sram_1r1w_masked.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sram_1r1w_masked.sv
// sram_1r1w_masked
//    One-read / one-write SRAM model with per-segment write masks, an optional
//    read-under-write bypass and an optional read-data hold. After reset a
//    self-clearing init pass writes zero to every entry. Both ports stay
//    closed until that pass has finished.
//
// Ports
//    clock, reset        single clock; synchronous active-high reset
//    r_valid/r_ready     read request / read port accepting
//    r_addr              read address
//    r_data/r_data_valid read response, one cycle after the read fires
//    w_valid/w_ready     write request / write port accepting
//    w_addr/w_data       write address / data
//    w_mask              per-segment write enable (bit i -> segment i)
//    init_done           high once the clear pass has completed
//
// Init FSM states
//    state | meaning
//    INIT  | clearing entry[cnt] each cycle, ports closed
//    RUN   | array cleared, both ports open until the next reset
module sram_1r1w_masked #(
   parameter  int DEPTH     = 128,
   parameter  int WIDTH     = 22,
   parameter  int SEGS      = 1,
   parameter  int BYPASS    = 1,
   parameter  int HOLD_READ = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             r_valid,
   output logic             r_ready,
   input  logic [AW-1:0]    r_addr,
   output logic [WIDTH-1:0] r_data,
   output logic             r_data_valid,
   input  logic             w_valid,
   output logic             w_ready,
   input  logic [AW-1:0]    w_addr,
   input  logic [WIDTH-1:0] w_data,
   input  logic [SEGS-1:0]  w_mask,
   output logic             init_done
);

   localparam int            SW      = WIDTH / SEGS;
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

   typedef enum logic {INIT, RUN} state_t;

   state_t           state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] r_data_q, r_data_d;
   logic             r_data_valid_q;

   logic             r_fire, w_fire;
   logic             r_in_range, w_in_range;
   logic             collide;
   logic [WIDTH-1:0] mask_bits;
   logic [WIDTH-1:0] old_data;
   logic [WIDTH-1:0] rd_val;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   assign init_done = (state_q == RUN);
   assign r_ready   = init_done;
   assign w_ready   = init_done;

   assign r_fire = r_valid && r_ready;
   assign w_fire = w_valid && w_ready;

   // Non-power-of-two depths leave a hole at the top of the address space.
   assign r_in_range = ({1'b0, r_addr} < DEPTH_W);
   assign w_in_range = ({1'b0, w_addr} < DEPTH_W);

   always_comb begin
      mask_bits = '0;
      for (int s = 0; s < SEGS; s++) begin
         mask_bits[s*SW +: SW] = {SW{w_mask[s]}};
      end
   end

   assign old_data = r_in_range ? mem_q[r_addr] : '0;
   assign collide  = (BYPASS != 0) && w_fire && w_in_range && (r_addr == w_addr);
   assign rd_val   = collide ? ((old_data & ~mask_bits) | (w_data & mask_bits)) : old_data;

   always_comb begin
      r_data_d = '0;
      if (r_fire)              r_data_d = rd_val;
      else if (HOLD_READ != 0) r_data_d = r_data_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= INIT;
         cnt_q          <= '0;
         r_data_q       <= '0;
         r_data_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         r_data_q       <= r_data_d;
         r_data_valid_q <= r_fire;
      end
   end

   // The array itself is not reset; the init pass clears it instead.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state_q == INIT) begin
            mem_q[cnt_q] <= '0;
         end else if (w_fire && w_in_range) begin
            for (int s = 0; s < SEGS; s++) begin
               if (w_mask[s]) mem_q[w_addr][s*SW +: SW] <= w_data[s*SW +: SW];
            end
         end
      end
   end

   assign r_data       = r_data_q;
   assign r_data_valid = r_data_valid_q;

endmodule

// File: tb/tb_sram_1r1w_masked.sv
// Testbench for sram_1r1w_masked. Two instances share one stimulus stream:
//    u_a: DEPTH=128, SEGS=2, BYPASS=1, HOLD_READ=1
//    u_b: DEPTH=100, SEGS=2, BYPASS=0, HOLD_READ=0
module tb_sram_1r1w_masked;

   logic        clock = 1'b0;
   logic        reset;
   logic        r_valid;
   logic [6:0]  r_addr;
   logic        w_valid;
   logic [6:0]  w_addr;
   logic [21:0] w_data;
   logic [1:0]  w_mask;

   logic        a_r_ready, a_w_ready, a_r_data_valid, a_init_done;
   logic [21:0] a_r_data;
   logic        b_r_ready, b_w_ready, b_r_data_valid, b_init_done;
   logic [21:0] b_r_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clock = ~clock;

   sram_1r1w_masked #(.DEPTH(128), .WIDTH(22), .SEGS(2), .BYPASS(1), .HOLD_READ(1)) u_a (
      .clock(clock), .reset(reset),
      .r_valid(r_valid), .r_ready(a_r_ready), .r_addr(r_addr),
      .r_data(a_r_data), .r_data_valid(a_r_data_valid),
      .w_valid(w_valid), .w_ready(a_w_ready), .w_addr(w_addr),
      .w_data(w_data), .w_mask(w_mask), .init_done(a_init_done)
   );

   sram_1r1w_masked #(.DEPTH(100), .WIDTH(22), .SEGS(2), .BYPASS(0), .HOLD_READ(0)) u_b (
      .clock(clock), .reset(reset),
      .r_valid(r_valid), .r_ready(b_r_ready), .r_addr(r_addr),
      .r_data(b_r_data), .r_data_valid(b_r_data_valid),
      .w_valid(w_valid), .w_ready(b_w_ready), .w_addr(w_addr),
      .w_data(w_data), .w_mask(w_mask), .init_done(b_init_done)
   );

   typedef struct {
      logic        rv;
      logic [6:0]  ra;
      logic        wv;
      logic [6:0]  wa;
      logic [21:0] wd;
      logic [1:0]  wm;
      logic        ev;
      logic [21:0] ea;
      logic [21:0] eb;
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   function automatic vec_t mk(logic rv, logic [6:0] ra, logic wv, logic [6:0] wa,
                               logic [21:0] wd, logic [1:0] wm, logic ev,
                               logic [21:0] ea, logic [21:0] eb);
      vec_t v;
      v.rv = rv; v.ra = ra; v.wv = wv; v.wa = wa; v.wd = wd; v.wm = wm;
      v.ev = ev; v.ea = ea; v.eb = eb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      else n_pass++;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic rv, input logic [6:0] ra, input logic wv,
                        input logic [6:0] wa, input logic [21:0] wd, input logic [1:0] wm);
      r_valid = rv; r_addr = ra; w_valid = wv; w_addr = wa; w_data = wd; w_mask = wm;
   endtask

   task automatic idle();
      drive(1'b0, 7'd0, 1'b0, 7'd0, 22'd0, 2'b00);
   endtask

   // Releases reset and walks the clear pass, checking init_done timing on both instances.
   task automatic init_pass(input string tag);
      reset = 1'b0;
      for (int k = 1; k <= 128; k++) begin
         step();
         chk($sformatf("%s_a_init_done_k%0d", tag, k), 32'(a_init_done), 32'(k == 128));
         chk($sformatf("%s_a_r_ready_k%0d", tag, k),   32'(a_r_ready),   32'(k == 128));
         chk($sformatf("%s_a_rvalid_k%0d", tag, k),    32'(a_r_data_valid), 32'd0);
         chk($sformatf("%s_b_init_done_k%0d", tag, k), 32'(b_init_done), 32'(k >= 100));
         chk($sformatf("%s_b_rvalid_k%0d", tag, k),    32'(b_r_data_valid), 32'(r_valid && k >= 101));
         chk($sformatf("%s_b_rdata_k%0d", tag, k),     32'(b_r_data),    32'd0);
      end
   endtask

   task automatic read_both(input string tag, input logic [6:0] a,
                            input logic [21:0] ea, input logic [21:0] eb);
      drive(1'b1, a, 1'b0, 7'd0, 22'd0, 2'b00);
      step();
      chk({tag, "_a_valid"}, 32'(a_r_data_valid), 32'd1);
      chk({tag, "_a_data"},  32'(a_r_data), 32'(ea));
      chk({tag, "_b_valid"}, 32'(b_r_data_valid), 32'd1);
      chk({tag, "_b_data"},  32'(b_r_data), 32'(eb));
   endtask

   initial begin
      vecs[0]  = mk(0, 7'd0,   1, 7'd5,   22'h3FFFFF, 2'b11, 0, 22'h000000, 22'h000000);
      vecs[1]  = mk(0, 7'd0,   1, 7'd5,   22'h000000, 2'b01, 0, 22'h000000, 22'h000000);
      vecs[2]  = mk(1, 7'd5,   0, 7'd0,   22'h000000, 2'b00, 1, 22'h3FF800, 22'h3FF800);
      vecs[3]  = mk(0, 7'd0,   1, 7'd9,   22'h00AAAA, 2'b11, 0, 22'h3FF800, 22'h000000);
      vecs[4]  = mk(1, 7'd9,   1, 7'd9,   22'h155555, 2'b11, 1, 22'h155555, 22'h00AAAA);
      vecs[5]  = mk(1, 7'd9,   0, 7'd0,   22'h000000, 2'b00, 1, 22'h155555, 22'h155555);
      vecs[6]  = mk(0, 7'd0,   1, 7'd3,   22'h001234, 2'b11, 0, 22'h155555, 22'h000000);
      vecs[7]  = mk(1, 7'd3,   0, 7'd0,   22'h000000, 2'b00, 1, 22'h001234, 22'h001234);
      vecs[8]  = mk(0, 7'd0,   0, 7'd0,   22'h000000, 2'b00, 0, 22'h001234, 22'h000000);
      vecs[9]  = mk(0, 7'd0,   0, 7'd0,   22'h000000, 2'b00, 0, 22'h001234, 22'h000000);
      vecs[10] = mk(0, 7'd0,   0, 7'd0,   22'h000000, 2'b00, 0, 22'h001234, 22'h000000);
      vecs[11] = mk(0, 7'd0,   0, 7'd0,   22'h000000, 2'b00, 0, 22'h001234, 22'h000000);
      vecs[12] = mk(1, 7'd9,   1, 7'd9,   22'h000000, 2'b01, 1, 22'h155000, 22'h155555);
      vecs[13] = mk(1, 7'd9,   0, 7'd0,   22'h000000, 2'b00, 1, 22'h155000, 22'h155000);
      vecs[14] = mk(1, 7'd5,   1, 7'd3,   22'h3FFFFF, 2'b10, 1, 22'h3FF800, 22'h3FF800);
      vecs[15] = mk(1, 7'd3,   0, 7'd0,   22'h000000, 2'b00, 1, 22'h3FFA34, 22'h3FFA34);
      vecs[16] = mk(0, 7'd0,   1, 7'd3,   22'h000000, 2'b00, 0, 22'h3FFA34, 22'h000000);
      vecs[17] = mk(1, 7'd3,   0, 7'd0,   22'h000000, 2'b00, 1, 22'h3FFA34, 22'h3FFA34);
      vecs[18] = mk(0, 7'd0,   1, 7'd120, 22'h000001, 2'b11, 0, 22'h3FFA34, 22'h000000);
      vecs[19] = mk(1, 7'd120, 0, 7'd0,   22'h000000, 2'b00, 1, 22'h000001, 22'h000000);
      vecs[20] = mk(1, 7'd99,  0, 7'd0,   22'h000000, 2'b00, 1, 22'h000000, 22'h000000);
      vecs[21] = mk(1, 7'd127, 0, 7'd0,   22'h000000, 2'b00, 1, 22'h000000, 22'h000000);
      vecs[22] = mk(1, 7'd56,  0, 7'd0,   22'h000000, 2'b00, 1, 22'h000000, 22'h000000);
      vecs[23] = mk(1, 7'd20,  0, 7'd0,   22'h000000, 2'b00, 1, 22'h000000, 22'h000000);

      reset = 1'b1;
      idle();
      repeat (3) step();
      chk("rst_a_r_ready",   32'(a_r_ready),      32'd0);
      chk("rst_a_w_ready",   32'(a_w_ready),      32'd0);
      chk("rst_a_init_done", 32'(a_init_done),    32'd0);
      chk("rst_a_rdata",     32'(a_r_data),       32'd0);
      chk("rst_a_rvalid",    32'(a_r_data_valid), 32'd0);
      chk("rst_b_w_ready",   32'(b_w_ready),      32'd0);
      chk("rst_b_rdata",     32'(b_r_data),       32'd0);

      // Clear pass with a read of entry 127 held the whole time.
      drive(1'b1, 7'd127, 1'b0, 7'd0, 22'd0, 2'b00);
      init_pass("init");
      idle();

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].rv, vecs[i].ra, vecs[i].wv, vecs[i].wa, vecs[i].wd, vecs[i].wm);
         step();
         chk($sformatf("vec%0d_a_valid", i), 32'(a_r_data_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_a_data", i),  32'(a_r_data),       32'(vecs[i].ea));
         chk($sformatf("vec%0d_b_valid", i), 32'(b_r_data_valid), 32'(vecs[i].ev));
         chk($sformatf("vec%0d_b_data", i),  32'(b_r_data),       32'(vecs[i].eb));
      end

      // Reset the cycle after a read fires: the pending response is discarded.
      read_both("inflight_rd", 7'd3, 22'h3FFA34, 22'h3FFA34);
      idle();
      reset = 1'b1;
      step();
      chk("inflight_a_valid",  32'(a_r_data_valid), 32'd0);
      chk("inflight_a_data",   32'(a_r_data),       32'd0);
      chk("inflight_b_valid",  32'(b_r_data_valid), 32'd0);
      chk("inflight_b_data",   32'(b_r_data),       32'd0);
      chk("inflight_a_ready",  32'(a_r_ready),      32'd0);

      // Reset again partway through the clear pass (cnt = 60).
      reset = 1'b0;
      repeat (60) step();
      chk("midinit_a_not_done", 32'(a_init_done), 32'd0);
      reset = 1'b1;
      step();
      init_pass("reinit");

      read_both("post_reinit_5",   7'd5,   22'h000000, 22'h000000);
      read_both("post_reinit_3",   7'd3,   22'h000000, 22'h000000);
      read_both("post_reinit_9",   7'd9,   22'h000000, 22'h000000);
      read_both("post_reinit_120", 7'd120, 22'h000000, 22'h000000);
      idle();
      step();
      chk("final_a_hold", 32'(a_r_data),       32'd0);
      chk("final_a_idle", 32'(a_r_data_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
